// File: rtl/life_pkg.sv
// ============================================================================
// Module   : life_pkg
// Brief    : Shared types and rule constants for the Life cell sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BIRTH_COUNT           = 3;
    localparam int SURVIVE_COUNT         = 2;
    localparam int DEFAULT_NUM_NEIGHBORS = 8;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full adder cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

`default_nettype wire

// File: rtl/ripple_incrementer.sv
// ============================================================================
// Module   : ripple_incrementer
// Brief    : Conditional +1 built as a ripple chain of full_adder cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_incrementer #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic [COUNT_WIDTH-1:0] value_i,
    input  logic                   carry_in_i,
    output logic [COUNT_WIDTH-1:0] result_o,
    output logic                   carry_out_o
);

    logic [COUNT_WIDTH:0] w_carry;

    assign w_carry[0]  = carry_in_i;
    assign carry_out_o = w_carry[COUNT_WIDTH];

    // Operand B is tied low: the chain only ever adds the carry-in.
    for (genvar i = 0; i < COUNT_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a_i    (value_i[i]),
            .b_i    (1'b0),
            .c_i    (w_carry[i]),
            .sum_o  (result_o[i]),
            .carry_o(w_carry[i+1])
        );
    end

endmodule

`default_nettype wire

// File: rtl/life_cell_sequencer.sv
// ============================================================================
// Module   : life_cell_sequencer
// Brief    : Counts live neighbours one bit per cycle on a shared incrementer
//            and applies the Conway rule; valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module life_cell_sequencer
    import life_pkg::*;
#(
    parameter  int NUM_NEIGHBORS = DEFAULT_NUM_NEIGHBORS,
    localparam int COUNT_WIDTH   = $clog2(NUM_NEIGHBORS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     alive_i,
    input  logic [NUM_NEIGHBORS-1:0] neighbors_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     next_alive_o,
    output logic [COUNT_WIDTH-1:0]   count_o
);

    localparam logic [COUNT_WIDTH-1:0]   IDX_LAST = COUNT_WIDTH'(NUM_NEIGHBORS - 1);
    localparam logic [NUM_NEIGHBORS-1:0] MASK_LSB = NUM_NEIGHBORS'(1);

    state_e                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [COUNT_WIDTH-1:0]   index_q, index_d;
    logic [NUM_NEIGHBORS-1:0] mask_q, mask_d;
    logic                     alive_q, alive_d;
    logic                     next_alive_q, next_alive_d;

    logic                     w_mask_bit;
    logic                     w_carry_in;
    logic [COUNT_WIDTH-1:0]   w_count_inc;
    logic                     w_carry_out;
    logic                     w_last;
    logic                     w_rule;

    assign w_mask_bit = |(mask_q & (MASK_LSB << index_q));
    assign w_carry_in = w_mask_bit & (state_q == ST_ACCUM);
    assign w_last     = (index_q == IDX_LAST);

    ripple_incrementer #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_inc (
        .value_i    (count_q),
        .carry_in_i (w_carry_in),
        .result_o   (w_count_inc),
        .carry_out_o(w_carry_out)
    );

    // The rule sees the count including the final add of this edge.
    assign w_rule = (int'(w_count_inc) == BIRTH_COUNT) |
                    (alive_q & (int'(w_count_inc) == SURVIVE_COUNT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            mask_q       <= '0;
            alive_q      <= 1'b0;
            next_alive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            mask_q       <= mask_d;
            alive_q      <= alive_d;
            next_alive_q <= next_alive_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        mask_d       = mask_q;
        alive_d      = alive_q;
        next_alive_d = next_alive_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    mask_d  = neighbors_i;
                    alive_d = alive_i;
                    count_d = '0;
                    index_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                count_d = w_count_inc;
                index_d = index_q + COUNT_WIDTH'(1);
                if (w_last) begin
                    next_alive_d = w_rule;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == ST_IDLE);
        out_valid_o  = (state_q == ST_DONE);
        count_o      = count_q;
        next_alive_o = next_alive_q;
    end

    // The count never exceeds NUM_NEIGHBORS, so the chain cannot overflow.
    always_comb begin
        assert (!((state_q == ST_ACCUM) && w_carry_out));
    end

endmodule

`default_nettype wire

// File: doc/life_cell_sequencer.md
Name: life_cell_sequencer

Overview:
- Sequential controller that time-multiplexes one shared ripple-increment datapath, built from existing full_adder cells, to count a cell's live neighbours one bit per cycle.
- Applies the Conway rule to the final count and presents the cell's next state on a valid/ready output.
- Sits between the grid-scan logic, which supplies one cell plus its 8-neighbour mask per transaction, and the next-generation write-back logic.
- Trades throughput for area versus a fully parallel adder tree.

Parameters:
- NUM_NEIGHBORS, 8, neighbour bits per cell; legal range 1..15.
- COUNT_WIDTH, $clog2(NUM_NEIGHBORS+1) (4), width of the live-neighbour count. Derived only; never overridden.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  neighbour mask and cell state valid
- IN_READY  output  1  sequencer idle; can accept
- ALIVE  input  1  current state of the cell
- NEIGHBORS  input  NUM_NEIGHBORS  live mask; bit i = neighbour i
- OUT_VALID  output  1  result valid; held until accepted
- OUT_READY  input  1  downstream accepts result
- NEXT_ALIVE  output  1  next-generation state of the cell
- COUNT  output  COUNT_WIDTH  live-neighbour count for the result

Behaviour:
- Clocking and reset:
  - Single clock domain, rising edge of CLK.
  - RST_N low asynchronously forces state IDLE, count 0, index 0, captured mask 0, captured ALIVE 0, NEXT_ALIVE 0.
  - Release is synchronous to CLK by upstream reset logic.
- Output values during reset: IN_READY=1, OUT_VALID=0, COUNT=0, NEXT_ALIVE=0.
- States:
  - IDLE: IN_READY=1, OUT_VALID=0. On IN_VALID&IN_READY at an edge, capture NEIGHBORS and ALIVE, clear count, index<=0, go to ACCUM.
  - ACCUM: IN_READY=0, OUT_VALID=0. Each edge: count <= count + mask[index]; index <= index+1. When index==NUM_NEIGHBORS-1 at an edge, perform the last add, register NEXT_ALIVE, and go to DONE.
  - DONE: OUT_VALID=1, IN_READY=0. COUNT and NEXT_ALIVE are stable. On OUT_VALID&OUT_READY at an edge, go to IDLE.
- Datapath:
  - The increment is a COUNT_WIDTH-bit ripple of full_adder cells.
  - Operand A is count, operand B is 0, and the carry-in of bit 0 is mask[index].
  - The carry-out of the MSB is ignored; it cannot occur by construction because the maximum count equals NUM_NEIGHBORS.
- Rule, evaluated on the final count:
  - NEXT_ALIVE = (count==BIRTH_COUNT) | (ALIVE_captured & count==SURVIVE_COUNT).
  - Constants: BIRTH_COUNT=3, SURVIVE_COUNT=2.
- Latency and throughput:
  - OUT_VALID rises NUM_NEIGHBORS edges after the input handshake edge.
  - IN_READY rises the edge after the output handshake.
  - Minimum period is NUM_NEIGHBORS+2 cycles per cell (10 by default).
- Boundary conditions:
  - Input changes after capture have no effect.
  - IN_VALID asserted in ACCUM/DONE is ignored; upstream holds it.
  - OUT_READY low in DONE holds outputs indefinitely.
  - OUT_READY high in IDLE/ACCUM has no effect.
  - Mask all-ones gives COUNT=NUM_NEIGHBORS with no wrap. Mask zero gives COUNT=0.
  - No combinational path from IN_VALID to IN_READY or from OUT_READY to OUT_VALID.
  - RST_N asserted mid-ACCUM or mid-DONE drops the transaction; outputs take reset values immediately.

Decomposition:
- Package life_pkg holds:
  - state enum (IDLE, ACCUM, DONE)
  - BIRTH_COUNT and SURVIVE_COUNT
  - default NUM_NEIGHBORS
- Sub-module ripple_incrementer (COUNT_WIDTH param) wraps the chain of full_adder instances: inputs VALUE, CARRY_IN; output RESULT.

Test Plan:
- Reset then idle: RST_N low 3 cycles -> IN_READY=1, OUT_VALID=0, COUNT=0, NEXT_ALIVE=0.
- Birth: ALIVE=0, NEIGHBORS=8'b0010_0101, OUT_READY=1 -> OUT_VALID exactly 8 cycles after handshake, COUNT=3, NEXT_ALIVE=1; IN_READY returns the following cycle.
- Survival and death:
  - ALIVE=1, NEIGHBORS=8'b1000_0001 -> COUNT=2, NEXT_ALIVE=1.
  - ALIVE=0 with the same mask -> NEXT_ALIVE=0.
  - ALIVE=1, NEIGHBORS=8'hFF -> COUNT=8, NEXT_ALIVE=0.
- Backpressure: OUT_READY low 5 cycles in DONE -> OUT_VALID, COUNT and NEXT_ALIVE held; IN_READY stays 0; a new IN_VALID is not accepted until 1 cycle after OUT_READY high.
- Input isolation: change NEIGHBORS from 8'h07 to 8'hFF during ACCUM -> COUNT=3, NEXT_ALIVE=1.
- Reset mid-operation: assert RST_N at the 4th ACCUM cycle -> outputs go to reset values immediately; the next transaction with 8'h00 gives COUNT=0.
